pll_lock_filter: RTL and testbench

// Qualifies the raw, asynchronous PLL lock indication before it reaches the

---
 rtl/pll_lock_filter_if.sv | 25 ++
 rtl/pll_lock_filter.sv | 109 ++++++++++
 tb/tb_pll_lock_filter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_filter_if.sv
// Lock filter signal bundle: raw lock and controls in, qualified lock and
// loss-of-lock debug status out.
interface pll_lock_filter_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  lock_raw_i;
  logic                  testmode_i;
  logic                  clr_i;
  logic                  lock_o;
  logic                  lost_o;
  logic [LOSS_CNT_W-1:0] loss_cnt_o;
  logic [1:0]            state_o;

  // Driver side (clock/reset generator or bench)
  modport master (
    output lock_raw_i, testmode_i, clr_i,
    input  lock_o, lost_o, loss_cnt_o, state_o
  );

  // Filter side
  modport slave (
    input  lock_raw_i, testmode_i, clr_i,
    output lock_o, lost_o, loss_cnt_o, state_o
  );
endinterface

// File: rtl/pll_lock_filter.sv
// PLL lock qualifier: synchronizes the raw lock, requires a settling period
// before asserting lock, rides through short dropouts and records genuine
// loss-of-lock events in a sticky flag plus a saturating counter.
module pll_lock_filter #(
  parameter int LOCK_WAIT  = 16,
  parameter int GLITCH_TOL = 4,
  parameter int LOSS_CNT_W = 8
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  pll_lock_filter_if.slave bus
);
  localparam int CMAX    = (LOCK_WAIT > GLITCH_TOL) ? LOCK_WAIT : GLITCH_TOL;
  localparam int CW      = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
  localparam int GT_LAST = (GLITCH_TOL > 0) ? GLITCH_TOL - 1 : 0;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [1:0]            sync_q;
  logic                  lock_s;
  logic                  loss_ev;
  logic                  lost_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic [LOSS_CNT_W-1:0] loss_base;

  assign lock_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous raw lock
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[0], bus.lock_raw_i};
  end

  // FSM state and shared settle/glitch counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state logic; loss_ev flags a confirmed loss of lock
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    loss_ev = 1'b0;
    unique case (state_q)
      UNLOCKED: if (lock_s) begin
        state_n = SETTLING;
        cnt_n   = '0;
      end
      SETTLING: begin
        if (!lock_s)                             state_n = UNLOCKED;
        else if (cnt_q == CW'(LOCK_WAIT - 1))    state_n = LOCKED;
        else                                     cnt_n   = cnt_q + 1'b1;
      end
      LOCKED: if (!lock_s) begin
        cnt_n = '0;
        if (GLITCH_TOL == 0) begin
          state_n = UNLOCKED;
          loss_ev = 1'b1;
        end else begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (lock_s)                              state_n = LOCKED;
        else if (cnt_q == CW'(GT_LAST)) begin
          state_n = UNLOCKED;
          loss_ev = 1'b1;
        end else                                 cnt_n   = cnt_q + 1'b1;
      end
      default: state_n = UNLOCKED;
    endcase
  end

  // Clear applies first so a coincident loss event still counts as one
  assign loss_base = bus.clr_i ? '0 : loss_cnt_q;

  // Sticky loss flag and saturating loss counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else if (loss_ev) begin
      lost_q     <= 1'b1;
      loss_cnt_q <= (&loss_base) ? loss_base : loss_base + 1'b1;
    end else if (bus.clr_i) begin
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end
  end

  // Lock decoded from state flops; testmode is the only combinational path
  assign bus.lock_o     = bus.testmode_i | (state_q == LOCKED) | (state_q == HOLD);
  assign bus.lost_o     = lost_q;
  assign bus.loss_cnt_o = loss_cnt_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pll_lock_filter.sv
// Bench for pll_lock_filter: scoreboard of cycle-stamped expectations,
// a table of lock dropout lengths, and hand sequences for reset/testmode.
module tb_pll_lock_filter;
  localparam int CW = 2;

  logic clk;
  logic rstn;

  pll_lock_filter_if #(.LOSS_CNT_W(CW)) bus ();

  pll_lock_filter #(.LOCK_WAIT(16), .GLITCH_TOL(4), .LOSS_CNT_W(CW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic        lock;
    logic [1:0]  st;
    logic        lost;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    int len;
    bit clr_evt;
  } vec_t;

  exp_t          sb[$];
  vec_t          vecs[10];
  int            cyc;
  int            checks;
  int            errors;
  logic          exp_lost;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int dc, input string nm, input logic lk, input logic [1:0] st);
    exp_t e;
    e.cyc  = cyc + dc;
    e.nm   = nm;
    e.lock = lk;
    e.st   = st;
    e.lost = exp_lost;
    e.cnt  = exp_cnt;
    sb.push_back(e);
  endtask

  // Compare every expectation due this cycle; anything older was missed
  task automatic score();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) chk({e.nm, "_sched"}, cyc, e.cyc);
      else begin
        chk({e.nm, "_lock"},  int'(bus.lock_o),     int'(e.lock));
        chk({e.nm, "_state"}, int'(bus.state_o),    int'(e.st));
        chk({e.nm, "_lost"},  int'(bus.lost_o),     int'(e.lost));
        chk({e.nm, "_cnt"},   int'(bus.loss_cnt_o), int'(e.cnt));
      end
    end
  endtask

  // Advance n rising edges; return at the following falling edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      score();
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    exp_lost = 1'b0; exp_cnt = '0;
    rstn = 1'b0;
    bus.lock_raw_i = 1'b0; bus.testmode_i = 1'b0; bus.clr_i = 1'b0;

    vecs[0] = '{1, 0}; vecs[1] = '{4, 0}; vecs[2] = '{5, 0}; vecs[3] = '{3, 0};
    vecs[4] = '{6, 0}; vecs[5] = '{5, 0}; vecs[6] = '{8, 0}; vecs[7] = '{5, 0};
    vecs[8] = '{5, 1}; vecs[9] = '{2, 0};

    // Reset state, then testmode forcing lock during reset
    #3;
    chk("rst_lock",  int'(bus.lock_o), 0);
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_lost",  int'(bus.lost_o), 0);
    chk("rst_cnt",   int'(bus.loss_cnt_o), 0);
    bus.testmode_i = 1'b1;
    #1 chk("rst_tm_lock", int'(bus.lock_o), 1);
    bus.testmode_i = 1'b0;
    step(3);
    rstn = 1'b1;
    step(2);

    // Rise, drop for one cycle after 10, rise again: restart without a loss
    bus.lock_raw_i = 1'b1;
    push(2, "t1_sync", 0, 0);
    push(3, "t1_settle", 0, 1);
    step(10);
    bus.lock_raw_i = 1'b0;
    step(1);
    bus.lock_raw_i = 1'b1;
    push(2,  "t2_drop", 0, 0);
    push(3,  "t2_resettle", 0, 1);
    push(18, "t2_pre", 0, 1);
    push(19, "t2_lock", 1, 2);
    step(22);

    // Dropout table: <=4 low samples absorbed, >=5 is a loss event
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].len <= 4) begin
        push(3, $sformatf("g%0d_hold", i), 1, 3);
        push(vecs[i].len + 3, $sformatf("g%0d_recover", i), 1, 2);
        push(vecs[i].len + 21, $sformatf("g%0d_steady", i), 1, 2);
      end else begin
        push(3, $sformatf("g%0d_hold", i), 1, 3);
        push(6, $sformatf("g%0d_hold_last", i), 1, 3);
        exp_lost = 1'b1;
        exp_cnt  = vecs[i].clr_evt ? CW'(1) : sat_inc(exp_cnt);
        push(7, $sformatf("g%0d_loss", i), 0, 0);
        push(vecs[i].len + 18, $sformatf("g%0d_pre", i), 0, 1);
        push(vecs[i].len + 19, $sformatf("g%0d_relock", i), 1, 2);
      end
      for (int t = 0; t < vecs[i].len + 22; t++) begin
        bus.lock_raw_i = (t >= vecs[i].len);
        bus.clr_i      = vecs[i].clr_evt && (t == 6);
        step(1);
      end
    end
    bus.clr_i = 1'b0;

    // Clear alone while locked: status clears, FSM untouched
    bus.clr_i = 1'b1;
    exp_lost = 1'b0; exp_cnt = '0;
    push(1, "clr_only", 1, 2);
    step(1);
    bus.clr_i = 1'b0;
    step(2);

    // Lose lock for good, then testmode forces lock without moving the FSM
    bus.lock_raw_i = 1'b0;
    push(6, "tm_hold", 1, 3);
    exp_lost = 1'b1; exp_cnt = CW'(1);
    push(7, "tm_loss", 0, 0);
    step(10);
    bus.testmode_i = 1'b1;
    #1 chk("tm_comb_lock", int'(bus.lock_o), 1);
    push(1, "tm_on", 1, 0);
    step(2);
    bus.testmode_i = 1'b0;
    push(1, "tm_off", 0, 0);
    step(1);

    // Lock, then reset asynchronously mid-LOCKED and relock from scratch
    bus.lock_raw_i = 1'b1;
    push(19, "ar_lock", 1, 2);
    step(22);
    #2 rstn = 1'b0;
    #1;
    chk("ar_lock_drop", int'(bus.lock_o), 0);
    chk("ar_state",     int'(bus.state_o), 0);
    chk("ar_lost",      int'(bus.lost_o), 0);
    step(2);
    rstn = 1'b1;
    exp_lost = 1'b0; exp_cnt = '0;
    push(18, "ar_pre", 0, 1);
    push(19, "ar_relock", 1, 2);
    step(21);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
